// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the four mux requesters and the round-robin arbiter.
// The arbiter takes the slave modport; the requester side takes the master modport.
interface mux_rr_arbiter_if #(
  parameter int unsigned CW = 8
);
  logic [3:0]    req;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          busy;
  logic [CW-1:0] hold_cnt;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  busy,
    input  hold_cnt
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output busy,
    output hold_cnt
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares the 4-input selector mux among four requesters.
// A requester keeps the grant for at most MAX_HOLD cycles while others are waiting.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_rr_arbiter_if.slave    bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // The counter stops here; with preemption disabled it stops at all-ones.
  localparam logic [CW-1:0] HoldSat = (MAX_HOLD != 0) ? CW'(MAX_HOLD) : {CW{1'b1}};

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [3:0]    owner_oh;
  logic [3:0]    others;

  // First set bit scanning p+1 .. p+4 (mod 4); returns p only if p is the sole requester.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    others            = bus.req & ~owner_oh;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req != 4'b0000) begin
          state_d = StGrant;
          owner_d = pick(bus.req, last_q);
          hold_d  = CW'(1);
        end
      end
      StGrant: begin
        if (!bus.req[owner_q]) begin
          last_d = owner_q;
          if (others != 4'b0000) begin
            owner_d = pick(bus.req, owner_q);
            hold_d  = CW'(1);
          end else begin
            state_d = StIdle;
            hold_d  = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_q >= HoldSat) && (others != 4'b0000)) begin
          last_d  = owner_q;
          owner_d = pick(bus.req, owner_q);
          hold_d  = CW'(1);
        end else if (hold_q != HoldSat) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    bus.gnt      = (state_q == StGrant) ? owner_oh : 4'b0000;
    bus.sel      = owner_q;
    bus.busy     = (state_q == StGrant);
    bus.hold_cnt = hold_q;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one instance with MAX_HOLD=8, one with MAX_HOLD=0.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_rr_arbiter_if #(.CW(8)) if8 ();
  mux_rr_arbiter_if #(.CW(8)) if0 ();

  mux_rr_arbiter #(.MAX_HOLD(8), .CW(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  mux_rr_arbiter #(.MAX_HOLD(0), .CW(8)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if8.req  = 4'b0000;
    if0.req  = 4'b0000;

    // Reset state
    #12;
    check("rst_gnt",  32'(if8.gnt), 32'h0);
    check("rst_sel",  32'(if8.sel), 32'h0);
    check("rst_busy", 32'(if8.busy), 32'h0);
    check("rst_hold", 32'(if8.hold_cnt), 32'h0);
    tick();
    rst_n = 1'b1;

    // Single request, 1-cycle latency, release to idle keeps sel
    if8.req = 4'b0100;
    tick();
    check("t1_gnt",  32'(if8.gnt), 32'h4);
    check("t1_sel",  32'(if8.sel), 32'h2);
    check("t1_busy", 32'(if8.busy), 32'h1);
    check("t1_hold", 32'(if8.hold_cnt), 32'h1);
    if8.req = 4'b0000;
    tick();
    check("t1_rel_gnt",  32'(if8.gnt), 32'h0);
    check("t1_rel_busy", 32'(if8.busy), 32'h0);
    check("t1_rel_sel",  32'(if8.sel), 32'h2);
    check("t1_rel_hold", 32'(if8.hold_cnt), 32'h0);

    // All four requesting: 0,1,2,3,0 each for exactly 8 cycles, no gaps
    rst_pulse();
    if8.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        exp_g = 4'b0001 << (g % 4);
        check("rr_gnt",  32'(if8.gnt), 32'(exp_g));
        check("rr_sel",  32'(if8.sel), 32'(g % 4));
        check("rr_hold", 32'(if8.hold_cnt), 32'(c + 1));
      end
    end

    // Owner 1 drops while 0 and 3 raise: pick after 1 is 3
    if8.req = 4'b0010;
    tick();
    check("t3_gnt1",  32'(if8.gnt), 32'h2);
    check("t3_hold1", 32'(if8.hold_cnt), 32'h1);
    tick();
    check("t3_hold2", 32'(if8.hold_cnt), 32'h2);
    if8.req = 4'b1001;
    tick();
    check("t3_gnt3",  32'(if8.gnt), 32'h8);
    check("t3_sel3",  32'(if8.sel), 32'h3);
    check("t3_hold3", 32'(if8.hold_cnt), 32'h1);

    // Sole requester 2 holds 20 cycles, counter saturates at 8
    if8.req = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check("t4_gnt",  32'(if8.gnt), 32'h4);
      check("t4_hold", 32'(if8.hold_cnt), 32'((c > 8) ? 8 : c));
    end
    if8.req = 4'b0101;
    tick();
    check("t4_pre_gnt",  32'(if8.gnt), 32'h1);
    check("t4_pre_sel",  32'(if8.sel), 32'h0);
    check("t4_pre_hold", 32'(if8.hold_cnt), 32'h1);

    // Hand over to 2 so sel is non-zero, then reset between edges
    if8.req = 4'b0100;
    tick();
    check("t6_pre_gnt", 32'(if8.gnt), 32'h4);
    check("t6_pre_sel", 32'(if8.sel), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_gnt",  32'(if8.gnt), 32'h0);
    check("t6_async_busy", 32'(if8.busy), 32'h0);
    check("t6_async_sel",  32'(if8.sel), 32'h0);
    if8.req = 4'b1010;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_gnt", 32'(if8.gnt), 32'h2);
    check("t6_sel", 32'(if8.sel), 32'h1);

    // MAX_HOLD=0: requester 0 never preempted, counter saturates at 255
    if8.req = 4'b0000;
    rst_pulse();
    if0.req = 4'b0011;
    for (int c = 1; c <= 300; c++) begin
      tick();
      check("t5_gnt",  32'(if0.gnt), 32'h1);
      check("t5_hold", 32'(if0.hold_cnt), 32'((c > 255) ? 255 : c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
